// File: rtl/gpio_team_select_pkg.sv
// gpio_team_select_pkg: shared constants, FSM encoding and helpers for the
// GPIO team-select register bank. Shadow/commit logic is compiled in only
// when GPIO_TEAM_SELECT_COMMIT_EN is defined.
package gpio_team_select_pkg;

    // Default geometry: Caravel exposes 38 GPIO pins, teams are numbered 1..12.
    localparam int NUM_GPIO_DEF  = 38;
    localparam int NUM_TEAMS_DEF = 12;

    // Byte offsets inside the 0x3200 window (only adr[15:0] is decoded).
    localparam logic [15:0] SEL_BASE   = 16'h0000;
    localparam logic [15:0] COMMIT_OFS = 16'h0100;
    localparam logic [15:0] STATUS_OFS = 16'h0104;
    localparam logic [15:0] ID_OFS     = 16'h0108;

    // Constant returned by the ID register.
    localparam logic [31:0] ID_VALUE = 32'h6750_0001;

    // Wishbone acknowledge handshake states.
    typedef enum logic [0:0] {
        ACK_IDLE   = 1'b0,
        ACK_ACTIVE = 1'b1
    } ack_state_e;

    // A team number above the highest valid team is meaningless to the
    // output mux, so it collapses to 0 (pin unowned).
    function automatic logic [7:0] clamp_team(input logic [7:0] value,
                                              input logic [7:0] max_team);
        return (value > max_team) ? 8'h00 : value;
    endfunction

endpackage

// File: rtl/gpio_team_select_if.sv
// gpio_team_select_if: Wishbone slave signals between the interconnect and
// the GPIO team-select register bank.
//
// Handshake: the master presents wbs_stb_i & wbs_cyc_i together with stable
// wbs_we_i/wbs_sel_i/wbs_adr_i/wbs_dat_i. An idle slave performs the access on
// the first clock edge that sees the request and raises wbs_ack_o for exactly
// the following cycle; wbs_dat_o is valid only while wbs_ack_o = 1. The slave
// ignores the request during the ack cycle, so a master that keeps the strobe
// high starts a fresh access one cycle after each ack (one access per two
// cycles at most). Dropping the strobe during the ack cycle is always safe.
interface gpio_team_select_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/gpio_team_select_wb_ack_fsm.sv
// wb_ack_fsm: two-state Wishbone acknowledge generator. Produces a one-cycle
// access-enable pulse when an idle slave sees a request, then a registered
// one-cycle ack. Shared by the GPIO-control and LA-control slaves.
module wb_ack_fsm
    import gpio_team_select_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       stb,
    input  logic       cyc,
    output logic       access_o,
    output logic       ack_o,
    output ack_state_e state_o
);

    localparam logic [0:0] ST_IDLE = ACK_IDLE;
    localparam logic [0:0] ST_ACK  = ACK_ACTIVE;

    logic [0:0] state;
    logic [0:0] state_next;

    // Next-state and access strobe: a request is only taken while idle, so
    // the ack cycle always separates two accesses.
    always_comb begin
        state_next = state;
        access_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stb && cyc) begin
                    access_o   = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack decodes straight from the state flop, so it is glitch-free and
    // drops on the same edge that resets or leaves the ACK state.
    assign ack_o   = (state == ST_ACK);
    assign state_o = ack_state_e'(state);

endmodule

// File: rtl/gpio_team_select.sv
// gpio_team_select: Wishbone register bank holding, per Caravel GPIO pin, the
// team number that drives the pin. With GPIO_TEAM_SELECT_COMMIT_EN defined,
// software edits a shadow copy and a COMMIT write copies it atomically into
// the active selection; without it, SEL writes land in the active selection
// directly and COMMIT/STATUS are inert.
module gpio_team_select
    import gpio_team_select_pkg::*;
#(
    parameter int NUM_TEAMS = NUM_TEAMS_DEF,
    parameter int NUM_GPIO  = NUM_GPIO_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    gpio_team_select_if.slave     wb,
    output logic [NUM_GPIO*8-1:0] gpio_sel_o,
    output logic                  dirty_o
);

    // Four pins per SEL word; the read array is padded to a power of two so
    // every decoded word index addresses storage or a constant zero.
    localparam int NUM_SEL_WORDS = (NUM_GPIO + 3) / 4;
    localparam int IDX_W         = (NUM_SEL_WORDS > 1) ? $clog2(NUM_SEL_WORDS) : 1;
    localparam int PAD_BYTES     = 4 << IDX_W;

    localparam logic [7:0]  MAX_TEAM   = 8'(NUM_TEAMS);
    localparam logic [13:0] SEL_BASE_W = SEL_BASE[15:2];
    localparam logic [13:0] COMMIT_W   = COMMIT_OFS[15:2];
    localparam logic [13:0] STATUS_W   = STATUS_OFS[15:2];
    localparam logic [13:0] ID_W       = ID_OFS[15:2];

    logic                        access;
    logic                        ack;
    ack_state_e                  fsm_state_dbg;
    logic                        wr_en;
    logic [13:0]                 word_adr;
    logic [13:0]                 sel_off;
    logic                        sel_hit;
    logic [IDX_W-1:0]            sel_idx;
    logic [NUM_GPIO-1:0][7:0]    active_q;
    logic [PAD_BYTES-1:0][7:0]   rd_bytes;
    logic [31:0]                 rd_data;
    logic [31:0]                 dat_q;
    logic                        dirty;
    logic                        unused_ok;

    wb_ack_fsm u_ack_fsm (
        .clk      (clk),
        .nrst     (nrst),
        .stb      (wb.wbs_stb_i),
        .cyc      (wb.wbs_cyc_i),
        .access_o (access),
        .ack_o    (ack),
        .state_o  (fsm_state_dbg)
    );

    // Word decode; a word below SEL_BASE wraps to a large offset and misses.
    assign word_adr = wb.wbs_adr_i[15:2];
    assign sel_off  = word_adr - SEL_BASE_W;
    assign sel_hit  = (sel_off < 14'(NUM_SEL_WORDS));
    assign sel_idx  = sel_off[IDX_W-1:0];
    assign wr_en    = access && wb.wbs_we_i;

`ifdef GPIO_TEAM_SELECT_COMMIT_EN
    logic                     commit_wr;
    logic [NUM_GPIO-1:0][7:0] shadow_q;

    assign commit_wr = wr_en && (word_adr == COMMIT_W) &&
                       wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
`endif

    // Per-pin storage: each pin owns one byte lane of one SEL word.
    for (genvar p = 0; p < NUM_GPIO; p++) begin : g_pin
        localparam int               LANE = p % 4;
        localparam logic [IDX_W-1:0] WORD = IDX_W'(p / 4);

        logic       pin_wr;
        logic [7:0] pin_wdata;
        logic [7:0] active_b;

        assign pin_wr    = wr_en && sel_hit && (sel_idx == WORD) && wb.wbs_sel_i[LANE];
        assign pin_wdata = clamp_team(wb.wbs_dat_i[8*LANE +: 8], MAX_TEAM);

`ifdef GPIO_TEAM_SELECT_COMMIT_EN
        logic [7:0] shadow_b;

        // Shadow byte: software's working copy, invisible to the pin mux.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                shadow_b <= 8'h00;
            end else if (pin_wr) begin
                shadow_b <= pin_wdata;
            end
        end

        // Active byte: every pin loads on the same commit edge, so the mux
        // never sees a partially applied selection.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                active_b <= 8'h00;
            end else if (commit_wr) begin
                active_b <= shadow_b;
            end
        end

        assign shadow_q[p] = shadow_b;
        assign rd_bytes[p] = shadow_b;
`else
        // Active byte written directly by SEL accesses.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                active_b <= 8'h00;
            end else if (pin_wr) begin
                active_b <= pin_wdata;
            end
        end

        assign rd_bytes[p] = active_b;
`endif

        assign active_q[p] = active_b;
    end

    // Byte lanes beyond the last pin read as zero.
    for (genvar q = NUM_GPIO; q < PAD_BYTES; q++) begin : g_pad
        assign rd_bytes[q] = 8'h00;
    end

`ifdef GPIO_TEAM_SELECT_COMMIT_EN
    assign dirty = (shadow_q != active_q);
`else
    assign dirty = 1'b0;
`endif

    // Read mux; COMMIT and unmapped offsets fall through to zero.
    always_comb begin
        rd_data = 32'h0000_0000;
        if (sel_hit) begin
            rd_data = rd_bytes[{sel_idx, 2'b00} +: 4];
        end else if (word_adr == STATUS_W) begin
            rd_data = {31'd0, dirty};
        end else if (word_adr == ID_W) begin
            rd_data = ID_VALUE;
        end
    end

    // Read data is captured with the access and cleared on the edge that
    // ends the ack, so the bus sees zero outside the ack cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            dat_q <= 32'h0000_0000;
        end else if (access && !wb.wbs_we_i) begin
            dat_q <= rd_data;
        end else begin
            dat_q <= 32'h0000_0000;
        end
    end

    assign wb.wbs_ack_o = ack;
    assign wb.wbs_dat_o = dat_q;
    assign gpio_sel_o   = active_q;
    assign dirty_o      = dirty;

    // Undecoded address bits; the FSM state stays visible for checker binds.
    assign unused_ok = ^{wb.wbs_adr_i[31:16], wb.wbs_adr_i[1:0], fsm_state_dbg};

endmodule

// File: doc/gpio_team_select.md
# gpio_team_select

Wishbone register bank that consumes the GPIO-control strobe and truncated address from the Wishbone interconnect and returns read data and a one-cycle acknowledge. It holds, for every Caravel GPIO pin, the team number whose design drives that pin. Software edits a shadow copy, then commits it atomically to the active selection consumed by the GPIO output mux.

## Interface
- NUM_TEAMS, 12, highest valid team number; select value 0 = pin unowned
- NUM_GPIO, 38, number of GPIO pins
- clk  in  1  system clock
- nrst  in  1  reset; one clock; reset is synchronous and active-low
- wbs_stb_i  in  1  strobe, already gated by the interconnect for the 0x3200 window
- wbs_cyc_i  in  1  bus cycle valid
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  truncated address; only [15:0] is decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge pulse
- wbs_dat_o  out  32  read data, valid while wbs_ack_o = 1
- gpio_sel_o  out  NUM_GPIO*8  active select; pin p occupies bits [8p+7:8p]
- dirty_o  out  1  shadow differs from active

## Operation
- Map (byte offsets, word aligned; adr[1:0] ignored):
  - 0x0000–0x0024: SEL words 0..9; word w byte b = pin 4w+b. Bytes for pins ≥ NUM_GPIO read 0 and ignore writes.
  - 0x0100: COMMIT; a write with sel[0]=1 and dat[0]=1 copies shadow → active. Reads 0.
  - 0x0104: STATUS; bit0 = dirty, other bits 0. Read-only.
  - 0x0108: ID; reads constant 32'h6750_0001. Read-only.
  - Other offsets: read 0, writes ignored, still acknowledged.
- Byte writes to SEL honour wbs_sel_i individually.
- A written select byte greater than NUM_TEAMS is stored as 0.
- Handshake FSM, two states:
  - IDLE: on stb & cyc → perform the access, go to ACK.
  - ACK: wbs_ack_o = 1 for exactly this cycle, then return to IDLE unconditionally.
  - stb held high past ack starts a new access one cycle later: back-to-back accesses occur at most every 2 cycles.
- dirty_o is combinational: shadow != active.

## Timing
- Reset values: wbs_ack_o = 0, wbs_dat_o = 0, gpio_sel_o = 0, shadow = 0, dirty_o = 0, state = IDLE.
- Latency: request sampled at edge N; shadow/active update and wbs_dat_o load at edge N; wbs_ack_o high in cycle N+1 only.
- Commit: gpio_sel_o changes on the same edge that raises ack; all pins change together, never partially.
- wbs_dat_o returns to 0 on the edge that ends ack.
- stb dropped while in ACK: ack still completes; no second access.
- nrst low mid-transaction: ack drops at the next edge, all state reset, pending write lost.

## Configuration
- GPIO_TEAM_SELECT_COMMIT_EN defined: shadow/commit behaviour as above.
- Undefined: no shadow registers; SEL writes update gpio_sel_o directly at edge N; SEL reads return active values; COMMIT is a no-op; STATUS reads 0; dirty_o tied 0.

## Structure
- Package gpio_team_select_pkg: NUM_GPIO default, register offset localparams (SEL_BASE, COMMIT_OFS, STATUS_OFS, ID_OFS), ID constant, and the two-state FSM enum.
- Sub-module wb_ack_fsm: the IDLE/ACK handshake generator, producing an access-enable pulse and wbs_ack_o; reusable by the LA-control slave.

## Test plan
- Reset: hold nrst low 3 cycles with stb high → ack 0, gpio_sel_o 0, ID read afterwards returns 32'h6750_0001 with ack exactly one cycle after request.
- Write SEL word 0 = 32'h0C03_0201, sel=4'hF, then read → reads 32'h0C03_0201; gpio_sel_o still 0; dirty_o = 1; COMMIT write 1 → pins 0..3 = 1,2,3,12, dirty_o = 0.
- Byte-enable write sel=4'b0010, data 32'h0000_0500 to word 1 → only pin 5 = 5 after commit; pins 4,6,7 unchanged.
- Out-of-range: write 8'h0D (13) to pin 8 → reads back 0. Write word 9 = 32'hFFFF_0707 → pins 36,37 = 7; upper bytes read 0.
- Unmapped offset 0x0200 write then read → acked, read 0, no register change; stb held high for 6 cycles → exactly 3 ack pulses.
- Reset asserted in the ACK cycle of a COMMIT → next cycle ack 0 and gpio_sel_o 0.
